corelet_seq: RTL
================

Name: corelet_seq

Overview:
- Instruction sequencer that generates the 34-bit corelet instruction bundle in hardware, replacing testbench-driven stimulus.
- For one tile pass it:
  - reads weights from xmem into L0 and loads them into the MAC array;
  - streams activations through L0 in execute mode;
  - drains the OFIFO through the SFU and writes results to pmem.
- Sits between the top-level control/host and the core (xmem, pmem, corelet).

Parameters:
- row, 8, MAC array rows (L0 width in vectors)
- col, 8, MAC array columns (number of weight vectors per tile)
- addr_w, 11, SRAM address width (fixed by the bundle layout)
- tmo, 255, drain watchdog limit in idle cycles

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  one-cycle pulse; begins a pass when idle
- w_base  input  11  xmem address of first weight vector
- x_base  input  11  xmem address of first activation vector
- p_base  input  11  pmem address of first result
- n_act  input  11  activation vectors to stream (0..2047)
- acc_en  input  1  value driven on the bundle acc bit during drain
- ofifo_valid  input  1  corelet OFIFO holds at least one psum vector
- inst  output  34  instruction bundle to core/corelet
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse on pass completion
- err  output  1  sticky drain-timeout flag; cleared by the next accepted start

Behaviour:
- Bundle layout, fixed:
  - inst[33] acc
  - inst[32] CEN_pmem, inst[31] WEN_pmem, inst[30:20] A_pmem
  - inst[19] CEN_xmem, inst[18] WEN_xmem, inst[17:7] A_xmem
  - inst[6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load
- CEN and WEN are active-low. ififo_wr and ififo_rd are always 0.
- All outputs are registered.
- IDLE bundle = 34'h1_800C_0000 (both SRAMs disabled, all enables 0).
- Reset (asynchronous): state=IDLE, inst=IDLE bundle, busy=0, done=0, err=0, all counters 0. The same applies when reset asserts mid-pass; no partial sequence resumes.
- Latching: start sampled high in IDLE latches w_base, x_base, p_base, n_act and acc_en, and clears err. start in any other state is ignored.
- States and cycle counts (i counts within the state):
  - WFETCH, col+1 cycles:
    - cycles 0..col-1: CEN_xmem=0, WEN_xmem=1, A_xmem=w_base+i.
    - l0_wr=1 on cycles 1..col (1-cycle SRAM read latency).
  - WLOAD, col cycles: l0_rd=1, load=1.
  - WGAP, row+col cycles: IDLE bundle (weight propagation).
    - Goes to ACT if n_act>0, else to DONE.
  - ACT, n_act+2 cycles:
    - xmem read at x_base+i on cycles 0..n_act-1.
    - l0_wr=1 on cycles 1..n_act.
    - l0_rd=1 and execute=1 on cycles 2..n_act+1.
  - DRAIN:
    - acc=acc_en throughout.
    - ofifo_rd asserted in the cycle after ofifo_valid is sampled high, while reads_issued<n_act. It is never asserted on two consecutive cycles.
    - Each ofifo_rd causes a pmem write two cycles later (CEN_pmem=0, WEN_pmem=0, A_pmem=p_base+k), k = write index.
    - Exit to DONE on the cycle after the n_act-th pmem write.
    - Watchdog: counts consecutive cycles with ofifo_valid=0 and reads outstanding. At tmo it sets err=1 and exits to DONE, completing any pending pmem writes first.
  - DONE, 1 cycle: done=1, IDLE bundle, then IDLE.
- Address arithmetic is modulo 2^11: base+i wraps 2047→0.
- Read and write enables are never asserted outside the cycles listed above.

Test Plan:
- Reset mid-WLOAD (reset=0 at cycle 5 of WLOAD) -> inst=34'h1_800C_0000 immediately (asynchronous), busy=0. After release, a fresh start runs a full pass.
- start with w_base=0, x_base=16, n_act=4, ofifo_valid tied 1:
  - A_xmem walks 0..7, then 16..19; l0_wr count=12; load count=8; execute count=4.
  - ofifo_rd pulses alternate; pmem writes at p_base..p_base+3.
  - done pulses exactly once.
- n_act=0 -> WFETCH/WLOAD/WGAP only; no execute or ofifo_rd. done at cycle (col+1)+col+(row+col)+1 = 34 after start.
- x_base=2046, n_act=3 -> A_xmem sequence 2046, 2047, 0. p_base=2047, n_act=2 -> A_pmem 2047, 0.
- ofifo_valid held 0 in DRAIN -> err=1 after 255 idle cycles, done pulses. The next start clears err.
- start pulsed again while busy, and acc_en toggled mid-pass -> both ignored; the bundle acc bit keeps the latched acc_en.

Source files
------------

// File: rtl/corelet_seq.sv
`default_nettype none
// ============================================================================
//  Module   : corelet_seq
//  Function : Hardware sequencer producing the 34-bit corelet instruction
//             bundle for one tile pass: weight fetch/load, activation stream,
//             OFIFO drain to pmem.
//  Revision : 1.0 - initial release
// ============================================================================
module corelet_seq #(
    parameter int ROW    = 8,
    parameter int COL    = 8,
    parameter int ADDR_W = 11,
    parameter int TMO    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] x_base,
    input  logic [ADDR_W-1:0] p_base,
    input  logic [ADDR_W-1:0] n_act,
    input  logic              acc_en,
    input  logic              ofifo_valid,
    output logic [33:0]       inst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int          CNT_W       = ADDR_W + 1;
    localparam int          WDOG_W      = $clog2(TMO + 1);
    localparam logic [33:0] c_idle_inst = 34'h1_800C_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WFETCH = 3'd1,
        S_WLOAD  = 3'd2,
        S_WGAP   = 3'd3,
        S_ACT    = 3'd4,
        S_DRAIN  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t              r_state, w_state_nx;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
    logic [ADDR_W-1:0]   r_w_base, r_x_base, r_p_base, r_n_act;
    logic                r_acc_en;
    logic [ADDR_W-1:0]   r_rd_cnt, r_wr_cnt;
    logic                r_rd_d1;
    logic [WDOG_W-1:0]   r_wdog, w_wdog_nx;
    logic                r_tmo, r_err, r_busy, r_done;
    logic [33:0]         r_inst, w_inst;
    logic                w_outstanding, w_tmo_hit, w_rd_nx, w_wr_nx;
    logic [ADDR_W-1:0]   w_wbase;

    assign w_outstanding = (r_rd_cnt != r_n_act);
    assign w_wdog_nx     = (r_state == S_DRAIN && !ofifo_valid && w_outstanding && !r_tmo)
                           ? r_wdog + WDOG_W'(1) : '0;
    assign w_tmo_hit     = (w_wdog_nx == WDOG_W'(TMO));
    // Weight base is not latched yet on the IDLE->WFETCH edge.
    assign w_wbase       = (r_state == S_IDLE) ? w_base : r_w_base;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + CNT_W'(1);
        case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                if (start) w_state_nx = S_WFETCH;
            end
            S_WFETCH: if (r_cnt == CNT_W'(COL)) begin
                w_state_nx = S_WLOAD;
                w_cnt_nx   = '0;
            end
            S_WLOAD: if (r_cnt == CNT_W'(COL - 1)) begin
                w_state_nx = S_WGAP;
                w_cnt_nx   = '0;
            end
            S_WGAP: if (r_cnt == CNT_W'(ROW + COL - 1)) begin
                w_state_nx = (r_n_act != '0) ? S_ACT : S_DONE;
                w_cnt_nx   = '0;
            end
            S_ACT: if (r_cnt == {1'b0, r_n_act} + CNT_W'(1)) begin
                w_state_nx = S_DRAIN;
                w_cnt_nx   = '0;
            end
            S_DRAIN: begin
                w_cnt_nx = '0;
                // On timeout, leave only once no read is still owed its pmem write.
                if (r_wr_cnt == r_n_act || (r_tmo && !r_inst[6] && !r_rd_d1))
                    w_state_nx = S_DONE;
            end
            S_DONE: begin
                w_cnt_nx   = '0;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_cnt_nx   = '0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign w_rd_nx = (r_state == S_DRAIN) && (w_state_nx == S_DRAIN) && ofifo_valid &&
                     w_outstanding && !r_inst[6] && !r_tmo;
    assign w_wr_nx = r_rd_d1 && (w_state_nx == S_DRAIN);

    always_comb begin
        w_inst = c_idle_inst;
        case (w_state_nx)
            S_WFETCH: begin
                if (w_cnt_nx < CNT_W'(COL)) begin
                    w_inst[19]   = 1'b0;
                    w_inst[17:7] = w_wbase + w_cnt_nx[ADDR_W-1:0];
                end
                if (w_cnt_nx != '0) w_inst[2] = 1'b1;
            end
            S_WLOAD: begin
                w_inst[3] = 1'b1;
                w_inst[0] = 1'b1;
            end
            S_ACT: begin
                if (w_cnt_nx < {1'b0, r_n_act}) begin
                    w_inst[19]   = 1'b0;
                    w_inst[17:7] = r_x_base + w_cnt_nx[ADDR_W-1:0];
                end
                if (w_cnt_nx != '0 && w_cnt_nx <= {1'b0, r_n_act}) w_inst[2] = 1'b1;
                if (w_cnt_nx >= CNT_W'(2)) begin
                    w_inst[3] = 1'b1;
                    w_inst[1] = 1'b1;
                end
            end
            S_DRAIN: begin
                w_inst[33] = r_acc_en;
                w_inst[6]  = w_rd_nx;
                if (w_wr_nx) begin
                    w_inst[32]    = 1'b0;
                    w_inst[31]    = 1'b0;
                    w_inst[30:20] = r_p_base + r_wr_cnt;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_inst   <= c_idle_inst;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_tmo    <= 1'b0;
            r_wdog   <= '0;
            r_rd_d1  <= 1'b0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_w_base <= '0;
            r_x_base <= '0;
            r_p_base <= '0;
            r_n_act  <= '0;
            r_acc_en <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_inst  <= w_inst;
            r_busy  <= (w_state_nx != S_IDLE);
            r_done  <= (w_state_nx == S_DONE);
            r_rd_d1 <= r_inst[6];
            r_wdog  <= w_wdog_nx;
            if (r_state == S_IDLE) begin
                r_rd_cnt <= '0;
                r_wr_cnt <= '0;
                r_tmo    <= 1'b0;
                if (start) begin
                    r_w_base <= w_base;
                    r_x_base <= x_base;
                    r_p_base <= p_base;
                    r_n_act  <= n_act;
                    r_acc_en <= acc_en;
                    r_err    <= 1'b0;
                end
            end
            if (w_rd_nx) r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
            if (w_wr_nx) r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
            if (w_tmo_hit) begin
                r_tmo <= 1'b1;
                r_err <= 1'b1;
            end
        end
    end

    assign inst = r_inst;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule
`default_nettype wire
